// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial input plus received-byte outputs of the 8N1 receiver.
interface uart_receiver_if;
  logic       rx;
  logic [7:0] data;
  logic       done;
  logic       fe;
  logic       busy;
  modport master (input rx, output data, done, fe, busy);
  modport slave (output rx, input data, done, fe, busy);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with centre sampling, DONE strobe and framing-error flag.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 400,
  parameter int CNT_W        = 9
) (
  input logic             clk,
  input logic             rst_n,
  uart_receiver_if.master u
);
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       idx, idx_n;
  logic [7:0]       shift, shift_n, data, data_n;
  logic             done, done_n, fe, fe_n, rx_m, rx_s;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      data  <= '0;
      done  <= 1'b0;
      fe    <= 1'b0;
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      data  <= data_n;
      done  <= done_n;
      fe    <= fe_n;
      rx_m  <= u.rx;
      rx_s  <= rx_m;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    data_n  = data;
    done_n  = 1'b0;
    fe_n    = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: if (cnt == HALF_M1) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n   = '0;
        shift_n = {rx_s, shift[7:1]};
        idx_n   = idx + 1'b1;
        if (idx == 3'd7) state_n = STOP;
      end
      STOP: if (cnt == LAST) begin
        cnt_n   = '0;
        state_n = rx_s ? IDLE : BRK;
        data_n  = rx_s ? shift : data;
        done_n  = rx_s;
        fe_n    = !rx_s;
      end
      BRK: begin
        // a line held low after a framing error must not look like a new start bit
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end
  assign u.data = data;
  assign u.done = done;
  assign u.fe   = fe;
  assign u.busy = state != IDLE;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed checks of the 8N1 receiver: reset, framing, glitch, break,
// back-to-back frames with a fast transmitter, and reset mid-frame.
module tb_uart_receiver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0;
  int done_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int d0, f0, lat, busy_low, fall;
  logic busy_at_done, rose;
  logic [7:0] rxq[$];
  uart_receiver_if u();
  uart_receiver #(.CLKS_PER_BIT(400), .CNT_W(9)) dut (.clk(clk), .rst_n(rst_n), .u(u));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (u.done) begin
      done_cnt++;
      rxq.push_back(u.data);
    end
    if (u.fe) fe_cnt++;
    if (u.done && u.fe) both_cnt++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop);
    u.rx = 1'b0;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      u.rx = b[i];
      tick(cpb);
    end
    u.rx = stop;
    tick(cpb);
  endtask
  initial begin
    u.rx = 1'b1;
    for (int i = 0; i < 5; i++) begin
      u.rx = i[0];
      tick(1);
    end
    chk("rst_data", u.data, 8'h00);
    chk("rst_done", u.done, 0);
    chk("rst_fe", u.fe, 0);
    chk("rst_busy", u.busy, 0);
    u.rx = 1'b1;
    rst_n = 1'b1;
    d0 = done_cnt; f0 = fe_cnt;
    tick(4000);
    chk("idle_done", done_cnt - d0, 0);
    chk("idle_fe", fe_cnt - f0, 0);
    d0 = done_cnt; f0 = fe_cnt; lat = 0; busy_low = 0; busy_at_done = 1'b1;
    fork send_byte(8'hA5, 400, 1'b1); join_none
    for (int n = 1; n <= 4100; n++) begin
      tick(1);
      if (u.done && lat == 0) begin
        lat = n;
        busy_at_done = u.busy;
      end
      if (n >= 3 && lat == 0 && !u.busy) busy_low++;
    end
    chk("a5_done", done_cnt - d0, 1);
    chk("a5_data", u.data, 8'hA5);
    chk("a5_fe", fe_cnt - f0, 0);
    checks++;
    assert (lat >= 3801 && lat <= 3803) else begin
      errors++;
      $error("FAIL a5_latency observed %0d expected 3801..3803", lat);
    end
    chk("a5_busy_low", busy_low, 0);
    chk("a5_busy_after", busy_at_done, 0);
    d0 = done_cnt; f0 = fe_cnt; fall = 0; rose = 1'b0;
    u.rx = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      if (n == 151) u.rx = 1'b1;
      tick(1);
      if (u.busy) rose = 1'b1;
      if (rose && !u.busy && fall == 0) fall = n;
    end
    checks++;
    assert (fall >= 200 && fall <= 210) else begin
      errors++;
      $error("FAIL glitch_busy_fall observed %0d expected 200..210", fall);
    end
    chk("glitch_done", done_cnt - d0, 0);
    chk("glitch_fe", fe_cnt - f0, 0);
    send_byte(8'h3C, 400, 1'b1);
    tick(100);
    chk("3c_done", done_cnt - d0, 1);
    chk("3c_data", u.data, 8'h3C);
    d0 = done_cnt; f0 = fe_cnt;
    send_byte(8'h81, 400, 1'b0);
    tick(2000);
    chk("brk_fe", fe_cnt - f0, 1);
    chk("brk_done", done_cnt - d0, 0);
    chk("brk_data", u.data, 8'h3C);
    chk("brk_busy", u.busy, 1);
    u.rx = 1'b1;
    tick(5);
    chk("brk_busy_rel", u.busy, 0);
    send_byte(8'h42, 400, 1'b1);
    tick(100);
    chk("42_done", done_cnt - d0, 1);
    chk("42_data", u.data, 8'h42);
    d0 = done_cnt; f0 = fe_cnt;
    rxq.delete();
    send_byte(8'h00, 392, 1'b1);
    send_byte(8'hFF, 392, 1'b1);
    send_byte(8'h55, 392, 1'b1);
    tick(500);
    chk("b2b_done", done_cnt - d0, 3);
    chk("b2b_fe", fe_cnt - f0, 0);
    chk("b2b_q0", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h00);
    chk("b2b_q1", rxq.size() > 1 ? rxq[1] : 8'hxx, 8'hFF);
    chk("b2b_q2", rxq.size() > 2 ? rxq[2] : 8'hxx, 8'h55);
    d0 = done_cnt; f0 = fe_cnt;
    fork send_byte(8'hC3, 400, 1'b1); join_none
    tick(2200);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mid_rst_data", u.data, 8'h00);
    chk("mid_rst_busy", u.busy, 0);
    tick(1850);
    chk("mid_rst_done", done_cnt - d0, 0);
    chk("mid_rst_fe", fe_cnt - f0, 0);
    // the rest of the aborted frame may resynchronise as a spurious byte; let it drain
    tick(4500);
    d0 = done_cnt;
    send_byte(8'h7E, 400, 1'b1);
    tick(100);
    chk("7e_done", done_cnt - d0, 1);
    chk("7e_data", u.data, 8'h7E);
    chk("never_both", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
